// File: rtl/ultrasonic_ranging_controller.sv
// One ultrasonic ranging measurement per start request: gated carrier burst, receiver
// blanking, then echo listening. Reports time of flight in clk cycles or a timeout.
module ultrasonic_ranging_controller #(
  parameter int HALF_PERIOD    = 625,
  parameter int BURST_CYCLES   = 8,
  parameter int BLANK_CYCLES   = 50000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int TOF_W          = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             echo_in,
  output logic             tx_out,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [TOF_W-1:0] tof_cycles
);

  localparam int HP_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [HP_W-1:0]  HP_LAST    = HP_W'(HALF_PERIOD - 1);
  localparam logic [TOF_W-1:0] BURST_LAST = TOF_W'(2 * HALF_PERIOD * BURST_CYCLES - 1);
  localparam logic [TOF_W-1:0] BLANK_LAST = TOF_W'(2 * HALF_PERIOD * BURST_CYCLES + BLANK_CYCLES - 1);
  localparam logic [TOF_W-1:0] TO_LAST    = TOF_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TOF_W-1:0] TO_VALUE   = TOF_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, BURST, BLANK, LISTEN} state_t;

  state_t           state, state_d;
  logic [TOF_W-1:0] cnt, cnt_d;
  logic [HP_W-1:0]  hp_cnt, hp_cnt_d;
  logic             tx_d, busy_d, done_d, timeout_d;
  logic [TOF_W-1:0] tof_d;
  logic             s1, s2, s3;
  logic             echo_edge;

  // Echo synchronizer; its 2-cycle latency is part of the reported time of flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= echo_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign echo_edge = s2 & ~s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hp_cnt     <= '0;
      tx_out     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      tof_cycles <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      hp_cnt     <= hp_cnt_d;
      tx_out     <= tx_d;
      busy       <= busy_d;
      done       <= done_d;
      timeout    <= timeout_d;
      tof_cycles <= tof_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    hp_cnt_d  = hp_cnt;
    tx_d      = tx_out;
    busy_d    = busy;
    done_d    = 1'b0;
    timeout_d = timeout;
    tof_d     = tof_cycles;
    case (state)
      IDLE: begin
        tx_d   = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d   = BURST;
          cnt_d     = '0;
          hp_cnt_d  = '0;
          tx_d      = 1'b1;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
          tof_d     = '0;
        end
      end
      BURST: begin
        cnt_d = cnt + TOF_W'(1);
        // Half-period phase counter avoids a modulo on cnt.
        if (hp_cnt == HP_LAST) begin
          hp_cnt_d = '0;
          tx_d     = ~tx_out;
        end else begin
          hp_cnt_d = hp_cnt + HP_W'(1);
        end
        if (cnt == BURST_LAST) begin
          tx_d    = 1'b0;
          state_d = BLANK;
        end
      end
      BLANK: begin
        cnt_d = cnt + TOF_W'(1);
        tx_d  = 1'b0;
        if (cnt == BLANK_LAST) state_d = LISTEN;
      end
      LISTEN: begin
        cnt_d = cnt + TOF_W'(1);
        tx_d  = 1'b0;
        // An echo in the final window cycle takes priority over the timeout.
        if (echo_edge) begin
          tof_d     = cnt;
          timeout_d = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else if (cnt == TO_LAST) begin
          tof_d     = TO_VALUE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ultrasonic_ranging_controller.sv
// Directed bench for ultrasonic_ranging_controller with a shortened timing set
// (H=4, B=2, blank=10, timeout=100): burst, echo, blanking, timeout, restart, reset.
module tb_ultrasonic_ranging_controller;

  localparam int TOF_W = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             echo_in;
  logic             tx_out;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [TOF_W-1:0] tof_cycles;

  int n_vec = 0;
  int n_err = 0;
  int c = 0;
  logic       flag;
  logic [15:0] pat;

  ultrasonic_ranging_controller #(
    .HALF_PERIOD(4),
    .BURST_CYCLES(2),
    .BLANK_CYCLES(10),
    .TIMEOUT_CYCLES(100),
    .TOF_W(TOF_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .echo_in(echo_in),
    .tx_out(tx_out),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .tof_cycles(tof_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  // One-cycle start pulse; on return the DUT is in the cycle with cnt=0.
  task automatic go();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c = 0;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    echo_in = 1'b0;
    pat     = 16'h0F0F;
    #2;
    chk("rst_tx", tx_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_tof", tof_cycles, 0);
    adv(2);
    rst = 1'b0;
    adv(2);
    chk("idle_busy", busy, 0);

    // Burst waveform followed by a normal echo.
    go();
    chk("t1_busy", busy, 1);
    for (int k = 0; k < 16; k++) begin
      chk("t1_tx", tx_out, pat[k]);
      adv(1);
    end
    flag = 1'b0;
    while (c < 26) begin
      if (tx_out !== 1'b0) flag = 1'b1;
      adv(1);
    end
    chk("t1_blank_tx", flag, 0);
    adv(12);
    echo_in = 1'b1;
    adv(2);
    chk("t2_done_pre", done, 0);
    chk("t2_busy_pre", busy, 1);
    adv(1);
    chk("t2_done", done, 1);
    chk("t2_tof", tof_cycles, 40);
    chk("t2_timeout", timeout, 0);
    chk("t2_busy", busy, 0);
    adv(1);
    chk("t2_done_1cyc", done, 0);
    chk("t2_tof_hold", tof_cycles, 40);
    echo_in = 1'b0;
    adv(5);

    // Echo pulse inside the blanking window is ignored.
    go();
    adv(18);
    echo_in = 1'b1;
    adv(3);
    echo_in = 1'b0;
    flag = 1'b0;
    while (c < 99) begin
      if (done !== 1'b0) flag = 1'b1;
      adv(1);
    end
    chk("t3_no_early_done", flag, 0);
    chk("t3_busy_99", busy, 1);
    adv(1);
    chk("t3_done", done, 1);
    chk("t3_timeout", timeout, 1);
    chk("t3_tof", tof_cycles, 100);
    chk("t3_busy", busy, 0);
    adv(1);
    chk("t3_done_1cyc", done, 0);
    chk("t3_timeout_hold", timeout, 1);

    // Echo already high when listening starts yields a timeout.
    go();
    chk("t4_timeout_clr", timeout, 0);
    chk("t4_tof_clr", tof_cycles, 0);
    adv(20);
    echo_in = 1'b1;
    flag = 1'b0;
    while (c < 99) begin
      if (done !== 1'b0) flag = 1'b1;
      adv(1);
    end
    chk("t4_no_early_done", flag, 0);
    adv(1);
    chk("t4_done", done, 1);
    chk("t4_timeout", timeout, 1);
    chk("t4_tof", tof_cycles, 100);
    echo_in = 1'b0;
    adv(5);

    // start while busy is ignored; start in the done cycle is accepted.
    go();
    chk("t5_tof_clr", tof_cycles, 0);
    chk("t5_timeout_clr", timeout, 0);
    adv(5);
    start = 1'b1;
    adv(1);
    start = 1'b0;
    chk("t5_tx_c6", tx_out, 0);
    chk("t5_busy_c6", busy, 1);
    adv(24);
    start = 1'b1;
    adv(1);
    start = 1'b0;
    adv(7);
    echo_in = 1'b1;
    adv(3);
    chk("t5_done", done, 1);
    chk("t5_tof", tof_cycles, 40);
    start = 1'b1;
    adv(1);
    start = 1'b0;
    c = 0;
    echo_in = 1'b0;
    chk("t5_b2b_busy", busy, 1);
    chk("t5_b2b_tx", tx_out, 1);
    chk("t5_b2b_done", done, 0);
    chk("t5_b2b_tof", tof_cycles, 0);
    chk("t5_b2b_timeout", timeout, 0);

    // Asynchronous reset mid-burst.
    adv(3);
    chk("t6_tx_c3", tx_out, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_tx", tx_out, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_timeout", timeout, 0);
    chk("t6_tof", tof_cycles, 0);
    adv(1);
    rst = 1'b0;
    adv(3);
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_tx", tx_out, 0);
    go();
    chk("t6_restart_busy", busy, 1);
    chk("t6_restart_tx", tx_out, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ultrasonic_ranging_controller.md
Name: ultrasonic_ranging_controller

Overview:
Sequences one ultrasonic ranging measurement per request. It emits a gated 40 kHz burst of a set number of cycles on tx_out, which drives the transducer. It then blanks the receiver to reject ring-down and listens for an echo rising edge. It reports the time of flight in clk cycles, or a timeout. The block sits between the host-facing control/status registers and the transducer/echo comparator pins.

Parameters:
HALF_PERIOD, 625, clk cycles per half period of the 40 kHz carrier (50 MHz clk).
BURST_CYCLES, 8, number of full carrier periods per burst.
BLANK_CYCLES, 50000, clk cycles after the burst during which echo is ignored (1 ms).
TIMEOUT_CYCLES, 1500000, measurement window in clk cycles, counted from the first burst cycle (30 ms).
TOF_W, 24, width of the time-of-flight counter and result.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  synchronous request pulse; sampled only in IDLE.
echo_in  input  1  asynchronous echo comparator output.
tx_out  output  1  registered burst output to the transducer driver.
busy  output  1  high while a measurement is in progress (BURST, BLANK, LISTEN).
done  output  1  one-cycle pulse when a result is latched.
timeout  output  1  qualifies tof_cycles: 1 = no echo in window; held until the next start.
tof_cycles  output  TOF_W  measured time of flight in clk cycles; held until the next start.

Behaviour:
- Reset (async, immediate): state=IDLE, tx_out=0, busy=0, done=0, timeout=0, tof_cycles=0.
  - Echo synchronizer flops s1/s2/s3 = 0; cnt=0.
  - Reset mid-burst silences tx_out with no wait for a carrier edge.
- Echo path:
  - Chain s1<=echo_in, s2<=s1, s3<=s2.
  - edge = s2 & ~s3, giving a 2-cycle synchronizer latency that is included in tof_cycles.
  - The synchronizer runs in all states.
- cnt: TOF_W-bit cycle counter.
  - Equals 0 in the first BURST cycle and increments by 1 every cycle while busy.
  - Never wraps; TOF_W must hold TIMEOUT_CYCLES.
- Constraint: 2*HALF_PERIOD*BURST_CYCLES + BLANK_CYCLES < TIMEOUT_CYCLES.
- IDLE:
  - busy=0, tx_out=0.
  - On start=1: next cycle enters BURST with tx_out=1, busy=1, cnt=0, timeout=0, tof_cycles=0.
  - done is 0 in every cycle other than its pulse.
- BURST:
  - Lasts exactly 2*HALF_PERIOD*BURST_CYCLES cycles (cnt 0 .. 2*H*B-1).
  - tx_out toggles on the edge ending each cycle where (cnt+1) is a multiple of HALF_PERIOD, so each half period is exactly HALF_PERIOD cycles.
  - The first half period is high.
  - At the end of the last BURST cycle, tx_out<=0 and the state moves to BLANK.
- BLANK:
  - cnt 2*H*B .. 2*H*B+BLANK_CYCLES-1; edge is ignored; tx_out=0.
  - After the last BLANK cycle the state moves to LISTEN.
- LISTEN:
  - In any cycle with edge=1: tof_cycles<=cnt, timeout<=0, done<=1, busy<=0, state<=IDLE.
  - In the cycle with cnt==TIMEOUT_CYCLES-1 and edge=0: tof_cycles<=TIMEOUT_CYCLES, timeout<=1, done<=1, busy<=0, state<=IDLE.
  - If edge and the timeout cycle coincide, the echo wins (timeout=0, tof=TIMEOUT_CYCLES-1).
  - An echo already high on entry to LISTEN produces no edge; it must fall and rise again or the measurement times out.
- start while busy is ignored (no queueing).
- start during the done-pulse cycle (state is IDLE) is accepted.
  - done still lasts one cycle.
  - tof_cycles and timeout clear on the following edge.
- All outputs are registered.

Test Plan:
Parameters for all scenarios: HALF_PERIOD=4, BURST_CYCLES=2, BLANK_CYCLES=10, TIMEOUT_CYCLES=100. Burst occupies cnt 0..15, BLANK occupies cnt 16..25, LISTEN starts at cnt 26.
1. Burst waveform: 1-cycle start pulse -> busy rises next cycle. tx_out is 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0 over cnt 0..15, then 0 through BLANK.
2. Normal echo: echo_in driven high from the cycle with cnt=38 -> edge at cnt=40. done pulses for one cycle after it, with tof_cycles=40, timeout=0, busy=0.
3. Blanking: echo_in pulsed high during cnt 18..20, then held low -> no done before the window ends. At cnt=99, done=1, timeout=1, tof_cycles=100.
4. Echo stuck high: echo_in high from cnt 20 onward -> no edge in LISTEN. Result is timeout=1, tof_cycles=100.
5. Busy-ignore and back-to-back: start pulses at cnt=5 and cnt=30 are ignored, and one measurement completes. start asserted in the done cycle -> a new burst begins on the next cycle and tof_cycles/timeout read 0.
6. Async reset at cnt=3 (tx_out=1) -> tx_out, busy, done, timeout, tof_cycles = 0 immediately. After release, IDLE waits for start.
